srt4_quotient_otf: RTL and testbench

- Downstream consumer of the SRT radix-4 divider control FSM.
- Takes one signed quotient digit per iteration and builds the binary quotient on the fly, keeping the Q and QM (= Q - 1 ulp) registers.
- Applies the final negative-remainder correction by selecting QM, so no carry-propagate adder is needed.
- Presents the quotient with a single-cycle done pulse.

---
 rtl/srt4_pkg.sv | 21 ++
 rtl/srt4_quotient_otf_if.sv | 32 +++
 rtl/srt4_digit_decode.sv | 37 +++
 rtl/srt4_quotient_otf.sv | 116 +++++++++++
 tb/tb_srt4_quotient_otf.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/srt4_pkg.sv
// srt4_pkg -- shared definitions for the SRT radix-4 divider back end.
//   Digit codes (sign-magnitude, identical to the quotient-selection table),
//   default digit count and the on-the-fly converter state encoding.
package srt4_pkg;

    localparam int NDIG_DEF = 4;

    localparam logic [2:0] D0  = 3'b000;
    localparam logic [2:0] DP1 = 3'b001;
    localparam logic [2:0] DP2 = 3'b010;
    localparam logic [2:0] DN1 = 3'b101;
    localparam logic [2:0] DN2 = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_FIN = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/srt4_quotient_otf_if.sv
// srt4_quotient_otf_if -- digit/finalize handshake between the divider
// control FSM (master) and the on-the-fly quotient converter (slave).
//   start, digit_vld, digit[2:0], fin, rem_neg : master -> slave
//   quot[QW-1:0], busy, done, dcnt, err         : slave -> master
interface srt4_quotient_otf_if #(
    parameter int NDIG = 4
);
    localparam int QW = 2 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    logic          start;
    logic          digit_vld;
    logic [2:0]    digit;
    logic          fin;
    logic          rem_neg;
    logic [QW-1:0] quot;
    logic          busy;
    logic          done;
    logic [CW-1:0] dcnt;
    logic          err;

    modport master (
        output start, digit_vld, digit, fin, rem_neg,
        input  quot, busy, done, dcnt, err
    );

    modport slave (
        input  start, digit_vld, digit, fin, rem_neg,
        output quot, busy, done, dcnt, err
    );

endinterface

// File: rtl/srt4_digit_decode.sv
// srt4_digit_decode -- maps a signed radix-4 digit code to the append fields
// of the Q / QM on-the-fly registers.
//   code_i      : 3-bit sign-magnitude digit
//   q_fld_o     : 2-bit field appended to form the new Q
//   qm_fld_o    : 2-bit field appended to form the new QM
//   q_sel_qm_o  : new Q is built from QM (digit < 0)
//   qm_sel_q_o  : new QM is built from Q (digit > 0)
//   illegal_o   : code is not one of the five legal digits (decoded as 0)
module srt4_digit_decode
    import srt4_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [1:0] q_fld_o,
    output logic [1:0] qm_fld_o,
    output logic       q_sel_qm_o,
    output logic       qm_sel_q_o,
    output logic       illegal_o
);

    always_comb begin
        // default is digit 0: Q <- {Q,0}, QM <- {QM,3}
        q_fld_o    = 2'd0;
        qm_fld_o   = 2'd3;
        q_sel_qm_o = 1'b0;
        qm_sel_q_o = 1'b0;
        illegal_o  = 1'b0;
        case (code_i)
            D0:  ;
            DP1: begin q_fld_o = 2'd1; qm_fld_o = 2'd0; qm_sel_q_o = 1'b1; end
            DP2: begin q_fld_o = 2'd2; qm_fld_o = 2'd1; qm_sel_q_o = 1'b1; end
            DN1: begin q_fld_o = 2'd3; qm_fld_o = 2'd2; q_sel_qm_o = 1'b1; end
            DN2: begin q_fld_o = 2'd2; qm_fld_o = 2'd1; q_sel_qm_o = 1'b1; end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/srt4_quotient_otf.sv
// srt4_quotient_otf -- on-the-fly conversion of SRT radix-4 quotient digits
// into a two's complement quotient. Keeps Q and QM (= Q - 1 ulp) so that the
// negative-remainder correction is a register select rather than an adder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : srt4_quotient_otf_if.slave (start/digit/fin in, quot/status out)
// Optional: define SRT4_OTF_ERR_EN to enable the sticky protocol/illegal-digit
// error flag; otherwise err is constant 0 and illegal codes decode as 0.
module srt4_quotient_otf
    import srt4_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int QW   = 2 * NDIG
) (
    input  logic                clk,
    input  logic                rst,
    srt4_quotient_otf_if.slave  bus
);

    localparam int CW = $clog2(NDIG + 1);

    state_e        state_q, state_d;
    logic [QW-1:0] q_q, q_d;
    logic [QW-1:0] qm_q, qm_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          err_q, err_d;

    logic [1:0]    q_fld, qm_fld;
    logic          q_sel_qm, qm_sel_q, illegal;
    logic [QW-1:0] q_src, qm_src;
    logic          err_set;

    srt4_digit_decode u_dec (
        .code_i     (bus.digit),
        .q_fld_o    (q_fld),
        .qm_fld_o   (qm_fld),
        .q_sel_qm_o (q_sel_qm),
        .qm_sel_q_o (qm_sel_q),
        .illegal_o  (illegal)
    );

    assign q_src  = q_sel_qm ? qm_q : q_q;
    assign qm_src = qm_sel_q ? q_q  : qm_q;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        quot_d  = quot_q;
        dcnt_d  = dcnt_q;
        err_set = 1'b0;
        if (bus.start) begin
            // restart wins over digit_vld/fin; quot is deliberately kept
            state_d = ACCUM;
            q_d     = '0;
            qm_d    = '1;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ACCUM: begin
                    if (bus.digit_vld) begin
                        q_d    = {q_src[QW-3:0], q_fld};
                        qm_d   = {qm_src[QW-3:0], qm_fld};
                        dcnt_d = dcnt_q + CW'(1);
                        if (dcnt_q == CW'(NDIG - 1)) state_d = WAIT_FIN;
                        if (illegal) err_set = 1'b1;
                    end
                    if (bus.fin) err_set = 1'b1;
                end
                WAIT_FIN: begin
                    if (bus.fin) begin
                        quot_d  = bus.rem_neg ? qm_q : q_q;
                        state_d = DONE;
                    end else if (bus.digit_vld) begin
                        err_set = 1'b1;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SRT4_OTF_ERR_EN
    assign err_d = bus.start ? 1'b0 : (err_q | err_set);
`else
    // error tracking disabled: flag can never rise
    assign err_d = err_q & err_set & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            qm_q    <= '1;
            quot_q  <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            quot_q  <= quot_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.quot = quot_q;
    assign bus.busy = (state_q == ACCUM) || (state_q == WAIT_FIN);
    assign bus.done = (state_q == DONE);
    assign bus.dcnt = dcnt_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_srt4_quotient_otf.sv
module tb_srt4_quotient_otf;

    localparam int NDIG = 4;
`ifdef SRT4_OTF_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    srt4_quotient_otf_if #(.NDIG(NDIG)) ifc ();

    srt4_quotient_otf #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock: inputs already set, sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
    endtask

    task automatic push(input logic [2:0] d, input int gap);
        ifc.digit_vld = 1'b1;
        ifc.digit     = d;
        step();
        ifc.digit_vld = 1'b0;
        ifc.digit     = 3'b000;
        for (int i = 0; i < gap; i++) step();
    endtask

    task automatic finish(input string tag, input logic rn, input logic [7:0] exp);
        ifc.fin     = 1'b1;
        ifc.rem_neg = rn;
        step();
        ifc.fin     = 1'b0;
        ifc.rem_neg = 1'b0;
        chk({tag, "_quot"}, 32'(ifc.quot), 32'(exp));
        chk({tag, "_done"}, 32'(ifc.done), 32'd1);
        chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        step();
        chk({tag, "_done_off"}, 32'(ifc.done), 32'd0);
        chk({tag, "_quot_hold"}, 32'(ifc.quot), 32'(exp));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ifc.start = 1'b0; ifc.digit_vld = 1'b0; ifc.digit = 3'b000;
        ifc.fin = 1'b0; ifc.rem_neg = 1'b0;
        step(); step();
        chk("rst_quot", 32'(ifc.quot), 32'h0);
        chk("rst_busy", 32'(ifc.busy), 32'h0);
        chk("rst_done", 32'(ifc.done), 32'h0);
        chk("rst_dcnt", 32'(ifc.dcnt), 32'h0);
        chk("rst_err",  32'(ifc.err),  32'h0);
        chk("rst_q",    32'(dut.q_q),  32'h00);
        chk("rst_qm",   32'(dut.qm_q), 32'hFF);
        rst = 1'b0;
        step();

        // +1,+2,-1,0 -> Q=0x5C, QM=0x5B
        do_start();
        chk("a_busy", 32'(ifc.busy), 32'd1);
        push(3'b001, 0); push(3'b010, 0); push(3'b101, 0); push(3'b000, 0);
        chk("a_dcnt", 32'(ifc.dcnt), 32'd4);
        chk("a_busy_wait", 32'(ifc.busy), 32'd1);
        finish("a", 1'b0, 8'h5C);

        do_start();
        push(3'b001, 0); push(3'b010, 0); push(3'b101, 0); push(3'b000, 0);
        finish("b", 1'b1, 8'h5B);

        // -1,0,0,0 with intermediate Q checks; quot held across start
        do_start();
        chk("c_quot_held", 32'(ifc.quot), 32'h5B);
        push(3'b101, 0); chk("c_q1", 32'(dut.q_q), 32'hFF);
        push(3'b000, 0); chk("c_q2", 32'(dut.q_q), 32'hFC);
        push(3'b000, 0); chk("c_q3", 32'(dut.q_q), 32'hF0);
        push(3'b000, 0);
        finish("c", 1'b0, 8'hC0);

        // +2 x4 with idle gaps 1..3
        do_start();
        push(3'b010, 1); push(3'b010, 2); push(3'b010, 3); push(3'b010, 1);
        chk("d_dcnt", 32'(ifc.dcnt), 32'd4);
        finish("d", 1'b0, 8'hAA);

        // -2 x4 wraps modulo 2^8
        do_start();
        push(3'b110, 2); push(3'b110, 0); push(3'b110, 3); push(3'b110, 0);
        finish("e", 1'b0, 8'h56);

        // start together with digit_vld after two digits
        do_start();
        push(3'b001, 0); push(3'b010, 0);
        chk("f_dcnt2", 32'(ifc.dcnt), 32'd2);
        ifc.start = 1'b1; ifc.digit_vld = 1'b1; ifc.digit = 3'b010;
        step();
        ifc.start = 1'b0; ifc.digit_vld = 1'b0; ifc.digit = 3'b000;
        chk("f_dcnt0", 32'(ifc.dcnt), 32'd0);
        chk("f_q0", 32'(dut.q_q), 32'h00);
        push(3'b001, 0); push(3'b000, 0); push(3'b000, 0); push(3'b000, 0);
        finish("f", 1'b0, 8'h40);

        // illegal code accumulated as 0; extra digit in WAIT_FIN ignored
        do_start();
        push(3'b001, 0); push(3'b100, 0);
        chk("g_err", 32'(ifc.err), 32'(ERR_EXP));
        push(3'b000, 0); push(3'b000, 0);
        push(3'b010, 0);
        chk("g_dcnt", 32'(ifc.dcnt), 32'd4);
        chk("g_err_sticky", 32'(ifc.err), 32'(ERR_EXP));
        ifc.fin = 1'b1; ifc.rem_neg = 1'b1;
        step();
        ifc.fin = 1'b0; ifc.rem_neg = 1'b0;
        chk("g_quot", 32'(ifc.quot), 32'h3F);
        chk("g_done", 32'(ifc.done), 32'd1);
        step();

        // start clears err; fin in ACCUM flags it and is otherwise ignored
        do_start();
        chk("h_err_clr", 32'(ifc.err), 32'd0);
        ifc.fin = 1'b1;
        step();
        ifc.fin = 1'b0;
        chk("h_err_fin", 32'(ifc.err), 32'(ERR_EXP));
        chk("h_busy", 32'(ifc.busy), 32'd1);
        chk("h_done", 32'(ifc.done), 32'd0);

        // reset mid-ACCUM
        push(3'b001, 0); push(3'b010, 0);
        rst = 1'b1;
        step();
        chk("i_quot", 32'(ifc.quot), 32'h0);
        chk("i_busy", 32'(ifc.busy), 32'h0);
        chk("i_done", 32'(ifc.done), 32'h0);
        chk("i_dcnt", 32'(ifc.dcnt), 32'h0);
        chk("i_err",  32'(ifc.err),  32'h0);
        chk("i_q",    32'(dut.q_q),  32'h00);
        chk("i_qm",   32'(dut.qm_q), 32'hFF);
        rst = 1'b0;
        step();

        // IDLE ignores digits and fin
        push(3'b010, 0);
        ifc.fin = 1'b1;
        step();
        ifc.fin = 1'b0;
        chk("j_dcnt", 32'(ifc.dcnt), 32'd0);
        chk("j_done", 32'(ifc.done), 32'd0);
        chk("j_busy", 32'(ifc.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
